// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave backed by a DEPTH-word register array.
// One outstanding write and one outstanding read; OKAY/DECERR responses.
module axi_lite_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic in_rng(
    input logic [ADDR_WIDTH-1:0] a
  );
    return (a >> (LSB + IW)) == '0;
  endfunction

  logic                  init_q;
  logic                  aw_held_q, aw_held_d;
  logic [IW-1:0]         aw_idx_q, aw_idx_d;
  logic                  aw_ok_q, aw_ok_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NB-1:0]         wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic commit;
  logic [IW-1:0]         c_idx;
  logic                  c_ok;
  logic [DATA_WIDTH-1:0] c_data;
  logic [NB-1:0]         c_strb;
  logic [IW-1:0]         ar_idx;
  logic                  ar_ok;
  logic                  unused_addr;

  assign awready = init_q & ~aw_held_q & ~bvalid_q;
  assign wready  = init_q & ~w_held_q & ~bvalid_q;
  assign arready = init_q & ~rvalid_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign ar_hs = arvalid & arready;
  assign b_hs  = bvalid_q & bready;
  assign r_hs  = rvalid_q & rready;

  // A held half counts as available, so either arrival order commits.
  assign commit = (aw_held_q | aw_hs) & (w_held_q | w_hs);

  assign c_idx  = aw_held_q ? aw_idx_q : awaddr[LSB +: IW];
  assign c_ok   = aw_held_q ? aw_ok_q : in_rng(awaddr);
  assign c_data = w_held_q ? wdata_q : wdata;
  assign c_strb = w_held_q ? wstrb_q : wstrb;

  assign ar_idx = araddr[LSB +: IW];
  assign ar_ok  = in_rng(araddr);

  assign unused_addr = ^{awaddr[LSB-1:0], araddr[LSB-1:0]};

  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    aw_ok_d   = aw_ok_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (b_hs) begin
      bvalid_d = 1'b0;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = c_ok ? RESP_OKAY : RESP_DECERR;
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        aw_idx_d  = awaddr[LSB +: IW];
        aw_ok_d   = in_rng(awaddr);
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        wdata_d  = wdata;
        wstrb_d  = wstrb;
      end
    end
  end

  // Reads sample mem_q before this edge's write lands.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (r_hs) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = ar_ok ? mem_q[ar_idx] : '0;
      rresp_d  = ar_ok ? RESP_OKAY : RESP_DECERR;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      init_q    <= 1'b0;
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      aw_ok_q   <= 1'b0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      init_q    <= 1'b1;
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      aw_ok_q   <= aw_ok_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit && c_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (c_strb[b]) begin
          mem_q[c_idx][8*b +: 8] <= c_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: doc/axi_lite_slave_mem.md
Name: axi_lite_slave_mem

Overview:
- AXI4-Lite responder (slave end) backed by a register-array memory of DEPTH words.
- Sits opposite an AXI4-Lite master driver. Used as a DUT-side memory model and as the slave VIP reference responder.
- Supports independent AW/W acceptance, byte strobes, and OKAY/DECERR responses.
- Allows one outstanding write and one outstanding read at a time.

Parameters:
- ADDR_WIDTH, 32, address bus width.
- DATA_WIDTH, 32, data bus width. Legal values are 32 or 64.
- DEPTH, 16, number of DATA_WIDTH-bit words. Must be a power of two, at least 2.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- awaddr  in  ADDR_WIDTH  write address.
- awvalid  in  1 / awready  out  1  write address handshake.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte enables.
- wvalid  in  1 / wready  out  1  write data handshake.
- bresp  out  2  write response.
- bvalid  out  1 / bready  in  1  write response handshake.
- araddr  in  ADDR_WIDTH  read address.
- arvalid  in  1 / arready  out  1  read address handshake.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response.
- rvalid  out  1 / rready  in  1  read data handshake.

Behaviour:
- Reset: one clock (aclk); reset aresetn is asynchronous, active-low.
  - While aresetn=0: awready, wready, arready, bvalid, rvalid = 0; bresp, rresp, rdata = 0; all memory words = 0; aw_held, w_held = 0.
  - Reset asserted mid-transaction abandons all in-flight handshakes immediately.
  - An init flop sets on the first rising edge after deassertion. All ready outputs are gated by it, so readys first go high one cycle after reset release.
- Address decode:
  - LSB = log2(DATA_WIDTH/8). Word index = addr[ADDR_WIDTH-1:LSB]. Low LSB address bits are ignored (unaligned addresses are treated as aligned).
  - index < DEPTH: in range, response OKAY = 2'b00.
  - Otherwise: DECERR = 2'b11. Writes have no effect; reads return rdata = 0.
- Write path:
  - awready = init & !aw_held & !bvalid.
  - wready = init & !w_held & !bvalid.
  - An AW handshake latches awaddr into aw_q and sets aw_held. A W handshake latches wdata/wstrb and sets w_held. AW and W may arrive in either order or in the same cycle.
  - Commit edge: the edge on which both halves become available, counting the current-cycle handshake or a held value.
  - On the commit edge:
    - Each byte lane i with wstrb[i]=1 is written (if in range).
    - bvalid <= 1, and bresp is set.
    - aw_held and w_held are cleared.
  - Latency: AW and W handshake in cycle N gives bvalid in cycle N+1.
  - bvalid and bresp stay stable until bvalid & bready. No new AW/W is accepted while bvalid=1.
  - Readys reassert in the cycle after the B handshake.
  - wstrb = 0 still completes with OKAY and leaves memory unchanged.
- Read path:
  - arready = init & !rvalid.
  - On an AR handshake in cycle N: rvalid=1 in N+1, with rdata/rresp captured from memory at that edge.
  - rdata and rresp are held stable until rvalid & rready. arready reasserts the cycle after the R handshake.
  - Back-to-back reads therefore achieve one transfer per 2 cycles.
- Simultaneous events:
  - A read handshake on the same edge as a write commit to the same word returns the pre-write data (read-before-write).
  - Read and write channels are fully independent. Neither blocks the other.
- Master holding bready/rready = 0 indefinitely: the block stalls on that channel only. It never drops valid or changes data.

Test Plan (DATA_WIDTH=32, DEPTH=16):
- Reset release → readys 0 in the release cycle and 1 one cycle later. Read 0x08 → rdata=0x00000000, rresp=00.
- AW 0x04 and W 0xDEADBEEF (wstrb=0xF) in the same cycle → bvalid next cycle, bresp=00. Read 0x04 → 0xDEADBEEF.
- W 0x11223344 with wstrb=0x5 presented 3 cycles before AW 0x04 (memory 0xDEADBEEF) → wready drops after W handshake, single bvalid after AW. Read 0x04 → 0xDE22BE44.
- AW 0x40 (out of range) + W → bresp=11. Read 0x40 → rresp=11, rdata=0. Word 0 unchanged.
- bready held 0 for 5 cycles → bvalid/bresp stable, awready=wready=0 throughout. Concurrent read of 0x04 completes normally.
- Read of 0x0C handshaken on the edge a write of 0xCAFEF00D to 0x0C commits → rdata = old value. A subsequent read returns 0xCAFEF00D.
- aresetn pulsed low while rvalid=1 and aw_held=1 → rvalid, awready, bvalid = 0 immediately. Memory reads back 0 after release.
